// File: rtl/csr_exec_unit.sv
// Execute-stage sequencer for Zicsr instructions: one read-modify-write against
// the CSR file per instruction, ending in writeback/retire or an illegal-instruction trap.
module csr_exec_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [2:0]  funct3,
  input  logic [11:0] csr_addr_in,
  input  logic [4:0]  rs1_idx,
  input  logic [63:0] rs1_data,
  input  logic [4:0]  rd_idx,
  input  logic [63:0] pc_in,
  output logic [11:0] csr_addr,
  output logic        csr_we,
  output logic [63:0] csr_wdata,
  input  logic [63:0] csr_rdata,
  input  logic        csr_illegal,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [63:0] wb_data,
  output logic        inst_retired,
  output logic        exc_valid,
  output logic [63:0] exc_cause,
  output logic [63:0] exc_tval,
  output logic [63:0] exc_pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP,
    S_EXC
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [2:0]  r_funct3;
  logic [11:0] r_addr;
  logic [4:0]  r_rs1_idx;
  logic [63:0] r_rs1_data;
  logic [4:0]  r_rd;
  logic [63:0] r_pc;
  logic [63:0] r_old_val;
  logic [63:0] r_new_val;
  logic [4:0]  r_wb_rd;
  logic [63:0] r_wb_data;
  logic [63:0] r_exc_cause;
  logic [63:0] r_exc_tval;
  logic [63:0] r_exc_pc;

  logic [63:0] w_operand;
  logic [63:0] w_new_val;
  logic [63:0] w_old_val;
  logic        w_write_intent;
  logic        w_illegal;
  logic        w_load_wb;
  logic        w_load_exc;

  // Operand selection, write intent and the RMW result; only meaningful in READ.
  always_comb begin
    w_operand      = r_funct3[2] ? {59'b0, r_rs1_idx} : r_rs1_data;
    w_write_intent = (r_funct3[1:0] == 2'b01) || (r_rs1_idx != 5'd0);
    case (r_funct3[1:0])
      2'b10:   w_new_val = csr_rdata | w_operand;
      2'b11:   w_new_val = csr_rdata & ~w_operand;
      default: w_new_val = w_operand;
    endcase
    w_illegal = csr_illegal
             || (r_funct3[1:0] == 2'b00)
             || (w_write_intent && (r_addr[11:10] == 2'b11));
    w_old_val = (r_state == S_READ) ? csr_rdata : r_old_val;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (inst_valid) w_next = S_READ;
      S_READ: begin
        if (w_illegal)           w_next = S_EXC;
        else if (w_write_intent) w_next = S_WRITE;
        else                     w_next = S_RESP;
      end
      S_WRITE: w_next = S_RESP;
      S_RESP:  w_next = S_IDLE;
      S_EXC:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_load_wb  = (w_next == S_RESP) && (r_rd != 5'd0);
    w_load_exc = (w_next == S_EXC);
  end

  // Response fields load on the edge entering their strobe cycle so they are
  // valid alongside the strobe and then hold until the next one.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_funct3    <= '0;
      r_addr      <= '0;
      r_rs1_idx   <= '0;
      r_rs1_data  <= '0;
      r_rd        <= '0;
      r_pc        <= '0;
      r_old_val   <= '0;
      r_new_val   <= '0;
      r_wb_rd     <= '0;
      r_wb_data   <= '0;
      r_exc_cause <= '0;
      r_exc_tval  <= '0;
      r_exc_pc    <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_IDLE) && inst_valid) begin
        r_funct3   <= funct3;
        r_addr     <= csr_addr_in;
        r_rs1_idx  <= rs1_idx;
        r_rs1_data <= rs1_data;
        r_rd       <= rd_idx;
        r_pc       <= pc_in;
      end
      if (r_state == S_READ) begin
        r_old_val <= csr_rdata;
        r_new_val <= w_new_val;
      end
      if (w_load_wb) begin
        r_wb_rd   <= r_rd;
        r_wb_data <= w_old_val;
      end
      if (w_load_exc) begin
        r_exc_cause <= 64'd2;
        r_exc_tval  <= {52'b0, r_addr};
        r_exc_pc    <= r_pc;
      end
    end
  end

  assign inst_ready   = (r_state == S_IDLE);
  assign csr_addr     = r_addr;
  assign csr_we       = (r_state == S_WRITE);
  assign csr_wdata    = r_new_val;
  assign inst_retired = (r_state == S_RESP);
  assign wb_valid     = (r_state == S_RESP) && (r_rd != 5'd0);
  assign wb_rd        = r_wb_rd;
  assign wb_data      = r_wb_data;
  assign exc_valid    = (r_state == S_EXC);
  assign exc_cause    = r_exc_cause;
  assign exc_tval     = r_exc_tval;
  assign exc_pc       = r_exc_pc;

endmodule
